v_logic_pipe: RTL and testbench
===============================

// Module: v_logic_pipe
// PURPOSE
//  Parametrised vector bitwise-logic unit for the vALU; replaces the fixed 2-bit and/or/xor pipe.
//  - Full 8-op RVV logic set (vand/vor/vxor plus vm* mask-logical forms).
//  - SEW-aware per-element masking with mask-undisturbed merge from old vd.
//  - Configurable pipeline depth; valid/ready backpressure on the output.
// PARAMETERS
//  DATA_WIDTH   64  vector slice width in bits; must be a multiple of 64
//  ADDR_WIDTH   32  width of the destination address tag carried with each beat
//  LATENCY      5   accept-to-out_valid cycles with no stall; legal range 1..16
//  OPSEL_WIDTH  3   opcode width; fixed at 3
// PORTS
//  clk        in   1             clock
//  rst        in   1             reset: synchronous, active-high
//  in_valid   in   1             input beat present
//  in_ready   out  1             unit can accept a beat this cycle
//  in_addr    in   ADDR_WIDTH    destination tag, returned unchanged on out_addr
//  in_vec0    in   DATA_WIDTH    operand a (vs2)
//  in_vec1    in   DATA_WIDTH    operand b (vs1/scalar, already splatted)
//  in_vd      in   DATA_WIDTH    old destination value, used for masked-off elements
//  in_opSel   in   3             op select (see BEHAVIOUR)
//  in_sew     in   2             element width: 00=8, 01=16, 10=32, 11=64 bits
//  in_vm      in   1             1 = unmasked; 0 = apply in_mask
//  in_mask    in   DATA_WIDTH/8  per-element enable; bit i = element i
//  out_valid  out  1             result beat present
//  out_ready  in   1             downstream accepts the result beat
//  out_vec    out  DATA_WIDTH    result
//  out_addr   out  ADDR_WIDTH    tag of the result beat
// BEHAVIOUR
//  - Accept: a beat is accepted when in_valid && in_ready.
//  - in_ready = !(out_valid && !out_ready). Combinational; no dependence on in_valid.
//  - Ops (a=in_vec0, b=in_vec1):
//      000 a&b      001 ~(a&b)   010 a&~b    011 a^b
//      100 a|b      101 ~(a|b)   110 a|~b    111 ~(a^b)
//  - Masking, SEW=8<<in_sew:
//      - DATA_WIDTH/SEW elements; element i occupies bits [i*SEW +: SEW].
//      - Element i is active when in_vm || in_mask[i].
//      - in_mask bits at or above DATA_WIDTH/SEW are ignored.
//      - Active elements take the op result; inactive elements take in_vd bits unchanged.
//  - Pipeline:
//      - LATENCY stages, each holding {valid, vec, addr}.
//      - Op and merge are computed into stage 1; stages 2..LATENCY are pure delay.
//      - The last stage drives out_*.
//      - A beat accepted at edge k appears with out_valid=1 after edge k+LATENCY-1 when no stall occurs.
//      - Back-to-back accepts give one result per cycle; order is preserved; no beats are dropped or duplicated.
//  - Stall:
//      - While out_valid && !out_ready, every stage holds, including bubbles, and in_ready=0.
//      - When out_ready rises, the pipe advances on that same edge.
//  - Bubbles: a non-accepted cycle enters stage 1 with valid=0, vec=0, addr=0.
//    Data/addr of invalid stages are always 0.
//  - Outputs are held stable while out_valid && !out_ready.
//  - Reset:
//      - All stages clear; in-flight beats are discarded.
//      - out_valid=0, out_vec=0, out_addr=0; in_ready=1 from the first cycle after reset.
//      - A beat presented during rst is not accepted.
//  - in_valid with in_ready=0 is not accepted; the source must hold the beat.
// TESTING
//  1. LATENCY=5, op=000, a=FF00FF00_FF00FF00, b=0F0F0F0F_0F0F0F0F, vm=1, addr=0x40, out_ready=1
//     -> 5 cycles later: out_vec=0F000F00_0F000F00, out_addr=0x40, out_valid high for 1 cycle.
//  2. Each op 000..111 with a=0xAAAA.., b=0xCCCC.., vm=1
//     -> 8888,7777,2222,6666,EEEE,1111,BBBB,9999 (pattern repeated across the word).
//  3. SEW=16, vm=0, mask=0b0101, op=100, a=0, b=all-ones, vd=0x1234_5678_9ABC_DEF0
//     -> out_vec=0x1234_FFFF_9ABC_FFFF.
//  4. Backpressure: 8 back-to-back beats, out_ready low for 3 cycles after the first result
//     -> in_ready low during the stall, out_* stable, all 8 results in order, none lost or duplicated.
//  5. Reset with 3 beats in flight
//     -> no out_valid after reset; the next beat emerges after LATENCY cycles with the correct value.
//  6. LATENCY=1 and LATENCY=16 builds: random ops, SEW, mask and stalls
//     -> results match a scoreboard model with exact latency.

Source files
------------

// File: rtl/v_logic_pipe.sv
// Vector bitwise-logic unit: eight RVV logic ops and a per-element mask merge
// with old vd, followed by a LATENCY-deep stallable delay pipe.

module v_logic_lane (
  input  logic [2:0]  i_op,
  input  logic [63:0] i_a,
  input  logic [63:0] i_b,
  input  logic [63:0] i_vd,
  input  logic [1:0]  i_sew,
  input  logic        i_vm,
  input  logic [7:0]  i_mask,
  output logic [63:0] o_res
);
  logic [63:0] w_op;

  always_comb begin
    w_op = '0;
    case (i_op)
      3'b000: w_op = i_a & i_b;
      3'b001: w_op = ~(i_a & i_b);
      3'b010: w_op = i_a & ~i_b;
      3'b011: w_op = i_a ^ i_b;
      3'b100: w_op = i_a | i_b;
      3'b101: w_op = ~(i_a | i_b);
      3'b110: w_op = i_a | ~i_b;
      default: w_op = ~(i_a ^ i_b);
    endcase
  end

  // i_mask is already lane-local and element-indexed, so byte j maps to element j>>sew
  for (genvar j = 0; j < 8; j++) begin : g_byte
    logic w_en;
    assign w_en = (i_sew == 2'd0) ? i_mask[j]   :
                  (i_sew == 2'd1) ? i_mask[j/2] :
                  (i_sew == 2'd2) ? i_mask[j/4] : i_mask[0];
    assign o_res[j*8 +: 8] = (i_vm || w_en) ? w_op[j*8 +: 8] : i_vd[j*8 +: 8];
  end
endmodule

module v_logic_pipe #(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 32,
  parameter int LATENCY     = 5,
  parameter int OPSEL_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDR_WIDTH-1:0]   in_addr,
  input  logic [DATA_WIDTH-1:0]   in_vec0,
  input  logic [DATA_WIDTH-1:0]   in_vec1,
  input  logic [DATA_WIDTH-1:0]   in_vd,
  input  logic [OPSEL_WIDTH-1:0]  in_opSel,
  input  logic [1:0]              in_sew,
  input  logic                    in_vm,
  input  logic [DATA_WIDTH/8-1:0] in_mask,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_vec,
  output logic [ADDR_WIDTH-1:0]   out_addr
);
  localparam int NL = DATA_WIDTH / 64;

  logic                     w_adv;
  logic                     w_acc;
  logic [NL-1:0][7:0]       w_lane_mask;
  logic [NL-1:0][63:0]      w_merged;

  logic [LATENCY-1:0]       r_vld_pipe;
  logic [DATA_WIDTH-1:0]    r_vec  [LATENCY];
  logic [ADDR_WIDTH-1:0]    r_addr [LATENCY];

  // The whole pipe moves as one; any stall at the output freezes every stage.
  assign w_adv    = !(out_valid && !out_ready);
  assign w_acc    = in_valid && w_adv;
  assign in_ready = w_adv;

  for (genvar l = 0; l < NL; l++) begin : g_lane
    // Element count per lane shrinks with SEW, so pick the lane's slice of the mask accordingly
    assign w_lane_mask[l] = (in_sew == 2'd0) ? in_mask[l*8 +: 8] :
                            (in_sew == 2'd1) ? {4'b0, in_mask[l*4 +: 4]} :
                            (in_sew == 2'd2) ? {6'b0, in_mask[l*2 +: 2]} :
                                               {7'b0, in_mask[l]};
    v_logic_lane u_lane (
      .i_op   (in_opSel[2:0]),
      .i_a    (in_vec0[l*64 +: 64]),
      .i_b    (in_vec1[l*64 +: 64]),
      .i_vd   (in_vd[l*64 +: 64]),
      .i_sew  (in_sew),
      .i_vm   (in_vm),
      .i_mask (w_lane_mask[l]),
      .o_res  (w_merged[l])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_vec[i]  <= '0;
        r_addr[i] <= '0;
      end
    end else if (w_adv) begin
      r_vld_pipe[0] <= w_acc;
      r_vec[0]      <= w_acc ? w_merged : '0;
      r_addr[0]     <= w_acc ? in_addr  : '0;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        r_vec[i]      <= r_vec[i-1];
        r_addr[i]     <= r_addr[i-1];
      end
    end
  end

  assign out_valid = r_vld_pipe[LATENCY-1];
  assign out_vec   = r_vec[LATENCY-1];
  assign out_addr  = r_addr[LATENCY-1];
endmodule

// File: tb/tb_v_logic_pipe.sv
// Directed and scoreboard checks of v_logic_pipe at LATENCY 5, 1 and 16.
module tb_v_logic_pipe;
  localparam int DW = 64;
  localparam int AW = 32;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] addr;
  logic [DW-1:0] va, vb, vd;
  logic [2:0]    op;
  logic [1:0]    sew;
  logic          vm;
  logic [7:0]    mask;
  logic          ordy;
  logic          iv [3];
  logic          ir [3];
  logic          ov [3];
  logic [DW-1:0] ovec [3];
  logic [AW-1:0] oaddr [3];

  int n_tests = 0;
  int n_fail  = 0;

  v_logic_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LATENCY(5), .OPSEL_WIDTH(3)) u_dut5 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_addr(addr),
    .in_vec0(va), .in_vec1(vb), .in_vd(vd), .in_opSel(op), .in_sew(sew), .in_vm(vm),
    .in_mask(mask), .out_valid(ov[0]), .out_ready(ordy), .out_vec(ovec[0]), .out_addr(oaddr[0]));

  v_logic_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LATENCY(1), .OPSEL_WIDTH(3)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_addr(addr),
    .in_vec0(va), .in_vec1(vb), .in_vd(vd), .in_opSel(op), .in_sew(sew), .in_vm(vm),
    .in_mask(mask), .out_valid(ov[1]), .out_ready(ordy), .out_vec(ovec[1]), .out_addr(oaddr[1]));

  v_logic_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LATENCY(16), .OPSEL_WIDTH(3)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_addr(addr),
    .in_vec0(va), .in_vec1(vb), .in_vd(vd), .in_opSel(op), .in_sew(sew), .in_vm(vm),
    .in_mask(mask), .out_valid(ov[2]), .out_ready(ordy), .out_vec(ovec[2]), .out_addr(oaddr[2]));

  // Element-wise reference used by the random scoreboard
  function automatic logic [63:0] ref_fn(input logic [2:0] f_op, input logic [63:0] a,
                                         input logic [63:0] b, input logic [63:0] old,
                                         input logic [1:0] f_sew, input logic f_vm,
                                         input logic [7:0] m);
    logic [63:0] r;
    logic [63:0] res;
    int w;
    int n;
    case (f_op)
      3'd0: r = a & b;
      3'd1: r = ~(a & b);
      3'd2: r = a & ~b;
      3'd3: r = a ^ b;
      3'd4: r = a | b;
      3'd5: r = ~(a | b);
      3'd6: r = a | ~b;
      default: r = ~(a ^ b);
    endcase
    w = 8 << f_sew;
    n = 64 / w;
    res = old;
    for (int i = 0; i < n; i++)
      if (f_vm || m[i])
        for (int k = 0; k < w; k++) res[i*w + k] = r[i*w + k];
    return res;
  endfunction

  task automatic test_reset();
    logic quiet;
    rst = 1'b1; iv[0] = 1'b1; addr = 32'h55; va = '1; vb = '1; op = 3'd0; vm = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_tests++; if (ov[0] !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", ov[0]); end
    n_tests++; if (ovec[0] !== 64'h0) begin n_fail++; $display("FAIL rst_vec got %h exp 0", ovec[0]); end
    n_tests++; if (oaddr[0] !== 32'h0) begin n_fail++; $display("FAIL rst_addr got %h exp 0", oaddr[0]); end
    @(negedge clk);
    rst = 1'b0; iv[0] = 1'b0;
    #1;
    n_tests++; if (ir[0] !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b exp 1", ir[0]); end
    quiet = 1'b1;
    repeat (7) begin @(negedge clk); #1; if (ov[0] !== 1'b0) quiet = 1'b0; end
    n_tests++; if (!quiet) begin n_fail++; $display("FAIL rst_beat_accepted got out_valid exp none"); end
  endtask

  task automatic test_latency();
    @(negedge clk);
    iv[0] = 1'b1; op = 3'd0; vm = 1'b1; sew = 2'd0; mask = 8'h0; vd = '0; addr = 32'h40;
    va = 64'hFF00FF00_FF00FF00; vb = 64'h0F0F0F0F_0F0F0F0F;
    for (int t = 1; t <= 6; t++) begin
      @(negedge clk);
      iv[0] = 1'b0;
      #1;
      n_tests++;
      if (ov[0] !== (t == 5)) begin
        n_fail++; $display("FAIL lat_valid t=%0d got %b exp %b", t, ov[0], (t == 5));
      end
      if (t == 5) begin
        n_tests++;
        if (ovec[0] !== 64'h0F000F00_0F000F00 || oaddr[0] !== 32'h40) begin
          n_fail++; $display("FAIL lat_data got %h/%h exp 0f000f000f000f00/40", ovec[0], oaddr[0]);
        end
      end
    end
  endtask

  task automatic test_ops();
    logic [63:0] pat [8];
    pat = '{{16{4'h8}}, {16{4'h7}}, {16{4'h2}}, {16{4'h6}},
            {16{4'hE}}, {16{4'h1}}, {16{4'hB}}, {16{4'h9}}};
    va = {16{4'hA}}; vb = {16{4'hC}}; vm = 1'b1; sew = 2'd0; mask = 8'h0; vd = '0;
    for (int t = 0; t < 14; t++) begin
      @(negedge clk);
      if (t < 8) begin iv[0] = 1'b1; op = 3'(t); addr = 32'(t); end
      else iv[0] = 1'b0;
      #1;
      if (t >= 1) begin
        n_tests++;
        if (t >= 5 && t <= 12) begin
          if (ov[0] !== 1'b1 || ovec[0] !== pat[t-5] || oaddr[0] !== 32'(t-5)) begin
            n_fail++; $display("FAIL op%0d got v=%b %h/%h exp 1 %h/%0h", t-5, ov[0], ovec[0], oaddr[0], pat[t-5], t-5);
          end
        end else if (ov[0] !== 1'b0) begin
          n_fail++; $display("FAIL ops_idle t=%0d got out_valid %b exp 0", t, ov[0]);
        end
      end
    end
  endtask

  task automatic test_mask();
    logic [1:0]  t_sew [5];
    logic        t_vm  [5];
    logic [7:0]  t_msk [5];
    logic [2:0]  t_op  [5];
    logic [63:0] t_a   [5];
    logic [63:0] t_b   [5];
    logic [63:0] t_vd  [5];
    logic [63:0] t_exp [5];
    t_sew = '{2'd1, 2'd0, 2'd3, 2'd2, 2'd2};
    t_vm  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    t_msk = '{8'h05, 8'hA5, 8'hFE, 8'h02, 8'h00};
    t_op  = '{3'd4, 3'd0, 3'd0, 3'd3, 3'd1};
    t_a   = '{64'h0, '1, '1, '1, 64'h0};
    t_b   = '{'1, '1, '1, 64'h0, 64'h0};
    t_vd  = '{64'h1234_5678_9ABC_DEF0, 64'h0, 64'h1234_5678_9ABC_DEF0, 64'h0, {16{4'h5}}};
    t_exp = '{64'h1234_FFFF_9ABC_FFFF, 64'hFF00FF00_00FF00FF, 64'h1234_5678_9ABC_DEF0,
              64'hFFFFFFFF_00000000, 64'hFFFFFFFF_FFFFFFFF};
    for (int t = 0; t < 11; t++) begin
      @(negedge clk);
      if (t < 5) begin
        iv[0] = 1'b1; sew = t_sew[t]; vm = t_vm[t]; mask = t_msk[t]; op = t_op[t];
        va = t_a[t]; vb = t_b[t]; vd = t_vd[t]; addr = 32'h300 + 32'(t);
      end else iv[0] = 1'b0;
      #1;
      if (t >= 5 && t <= 9) begin
        n_tests++;
        if (ov[0] !== 1'b1 || ovec[0] !== t_exp[t-5] || oaddr[0] !== 32'h300 + 32'(t-5)) begin
          n_fail++; $display("FAIL mask%0d got v=%b %h exp %h", t-5, ov[0], ovec[0], t_exp[t-5]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_v [8];
    logic [63:0] hold_v;
    logic [31:0] hold_a;
    logic        quiet;
    int nxt, rcv, t;
    for (int j = 0; j < 8; j++) exp_v[j] = (64'h0101010101010101 * 64'(j+1)) ^ {8{8'hF0}};
    nxt = 0; rcv = 0; t = 0; hold_v = '0; hold_a = '0;
    op = 3'd3; vm = 1'b1; sew = 2'd0; mask = 8'h0; vb = {8{8'hF0}}; vd = '0;
    while (t < 40 && !(rcv == 8 && nxt == 8)) begin
      @(negedge clk);
      ordy  = !(t >= 6 && t <= 8);
      iv[0] = (nxt < 8);
      va    = 64'h0101010101010101 * 64'(nxt+1);
      addr  = 32'h100 + 32'(nxt);
      #1;
      if (t == 6) begin hold_v = ovec[0]; hold_a = oaddr[0]; end
      if (t >= 6 && t <= 8) begin
        n_tests++;
        if (ir[0] !== 1'b0 || ov[0] !== 1'b1 || ovec[0] !== hold_v || oaddr[0] !== hold_a) begin
          n_fail++; $display("FAIL stall t=%0d got rdy=%b v=%b %h exp rdy=0 v=1 %h", t, ir[0], ov[0], ovec[0], hold_v);
        end
      end
      if (ov[0] && ordy) begin
        n_tests++;
        if (rcv >= 8) begin
          n_fail++; $display("FAIL bp_extra got beat %h exp none", ovec[0]);
        end else if (ovec[0] !== exp_v[rcv] || oaddr[0] !== 32'h100 + 32'(rcv)) begin
          n_fail++; $display("FAIL bp%0d got %h/%h exp %h/%h", rcv, ovec[0], oaddr[0], exp_v[rcv], 32'h100 + 32'(rcv));
        end
        rcv++;
      end
      if (iv[0] && ir[0]) nxt++;
      t++;
    end
    @(negedge clk);
    iv[0] = 1'b0; ordy = 1'b1;
    n_tests++; if (rcv != 8) begin n_fail++; $display("FAIL bp_count got %0d exp 8", rcv); end
    quiet = 1'b1;
    repeat (6) begin #1; if (ov[0] !== 1'b0) quiet = 1'b0; @(negedge clk); end
    n_tests++; if (!quiet) begin n_fail++; $display("FAIL bp_dup got out_valid exp 0"); end
  endtask

  task automatic test_reset_flight();
    logic quiet;
    op = 3'd4; va = '1; vb = '0; vm = 1'b1; sew = 2'd0; mask = 8'h0; vd = '0; ordy = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk); iv[0] = 1'b1; addr = 32'h200 + 32'(t);
    end
    @(negedge clk); iv[0] = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    n_tests++; if (ir[0] !== 1'b1) begin n_fail++; $display("FAIL rf_in_ready got %b exp 1", ir[0]); end
    quiet = 1'b1;
    repeat (8) begin
      @(negedge clk); #1;
      if (ov[0] !== 1'b0 || ovec[0] !== 64'h0 || oaddr[0] !== 32'h0) quiet = 1'b0;
    end
    n_tests++; if (!quiet) begin n_fail++; $display("FAIL rf_flush got v=%b %h exp 0", ov[0], ovec[0]); end
    @(negedge clk);
    iv[0] = 1'b1; op = 3'd0; va = '1; vb = {16{4'h3}}; addr = 32'h77;
    for (int t = 1; t <= 6; t++) begin
      @(negedge clk); iv[0] = 1'b0; #1;
      n_tests++;
      if (ov[0] !== (t == 5) || (t == 5 && (ovec[0] !== {16{4'h3}} || oaddr[0] !== 32'h77))) begin
        n_fail++; $display("FAIL rf_next t=%0d got v=%b %h/%h exp %b 3333..../77", t, ov[0], ovec[0], oaddr[0], (t == 5));
      end
    end
  endtask

  // Random ops, SEW, mask and stalls on all three depths; each beat is checked for
  // data, tag, order and for emerging exactly LATENCY-1 pipe advances after acceptance.
  task automatic test_random();
    logic [63:0] sv   [3][64];
    logic [31:0] sa   [3][64];
    int          srec [3][64];
    int          wr [3], rd [3], adv [3], lat [3];
    logic        pend [3];
    logic [63:0] cur_exp;
    int          sent;
    lat = '{5, 1, 16};
    for (int k = 0; k < 3; k++) begin wr[k] = 0; rd[k] = 0; adv[k] = 0; pend[k] = 1'b0; end
    sent = 0; cur_exp = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      ordy = ($urandom_range(3) != 0);
      if (!pend[0] && !pend[1] && !pend[2] && sent < 40 && $urandom_range(3) != 0) begin
        va = {$urandom(), $urandom()}; vb = {$urandom(), $urandom()}; vd = {$urandom(), $urandom()};
        op = 3'($urandom_range(7)); sew = 2'($urandom_range(3)); vm = ($urandom_range(3) == 0);
        mask = 8'($urandom_range(255)); addr = $urandom();
        cur_exp = ref_fn(op, va, vb, vd, sew, vm, mask);
        pend = '{1'b1, 1'b1, 1'b1};
        sent++;
      end
      for (int k = 0; k < 3; k++) iv[k] = pend[k];
      #1;
      for (int k = 0; k < 3; k++) begin
        if (ov[k] && ordy) begin
          n_tests++;
          if (rd[k] == wr[k]) begin
            n_fail++; $display("FAIL rnd_L%0d got unexpected beat %h exp none", lat[k], ovec[k]);
          end else begin
            if (ovec[k] !== sv[k][rd[k]] || oaddr[k] !== sa[k][rd[k]] || adv[k] != srec[k][rd[k]] + lat[k] - 1) begin
              n_fail++;
              $display("FAIL rnd_L%0d beat%0d got %h/%h adv=%0d exp %h/%h adv=%0d", lat[k], rd[k],
                       ovec[k], oaddr[k], adv[k], sv[k][rd[k]], sa[k][rd[k]], srec[k][rd[k]] + lat[k] - 1);
            end
            rd[k]++;
          end
        end
        if (iv[k] && ir[k]) begin
          sv[k][wr[k]] = cur_exp; sa[k][wr[k]] = addr; srec[k][wr[k]] = adv[k] + 1;
          wr[k]++; pend[k] = 1'b0;
        end
        if (ir[k]) adv[k]++;
      end
      if (sent == 40 && !pend[0] && !pend[1] && !pend[2] &&
          rd[0] == wr[0] && rd[1] == wr[1] && rd[2] == wr[2]) break;
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) iv[k] = 1'b0;
    ordy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (rd[k] != 40) begin n_fail++; $display("FAIL rnd_L%0d_count got %0d exp 40", lat[k], rd[k]); end
    end
  endtask

  initial begin
    rst = 1'b1; ordy = 1'b1; addr = '0; va = '0; vb = '0; vd = '0;
    op = 3'd0; sew = 2'd0; vm = 1'b1; mask = 8'h0;
    for (int k = 0; k < 3; k++) iv[k] = 1'b0;
    test_reset();
    test_latency();
    test_ops();
    test_mask();
    test_back_to_back();
    test_reset_flight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
